booth_control_unit: RTL and testbench
=====================================

Name: booth_control_unit

Overview:
- Moore FSM sequencer for the radix-2 Booth multiplier datapath.
- Examines the multiplier LSB pair {q_0, q_1} and the datapath iteration counter.
- Issues one-hot strobes load, add, sub, shift and decr to the accumulator, multiplier and counter registers.
- Sits beside the datapath; the datapath owns the A/Q/Q-1 registers and the counter, which is reloaded on load.

Parameters:
- CNT_W, 2, width of the count input. The datapath counter is loaded with N (1..2^CNT_W-1) on load.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a multiplication; sampled in IDLE only.
- q_0  input  1  multiplier register bit Q[0].
- q_1  input  1  extra Booth bit Q[-1].
- count  input  CNT_W  datapath iteration counter; value before any pending decrement.
- load  output  1  load multiplicand/multiplier, clear A and Q[-1], set counter to N.
- add  output  1  A <= A + M.
- sub  output  1  A <= A - M.
- shift  output  1  arithmetic right shift of {A, Q, Q-1}.
- decr  output  1  counter <= counter - 1.
- done  output  1  one-cycle pulse; product valid in the datapath.

Behaviour:
- One clock domain. Reset is synchronous and active-low: on a clk rising edge with rst_n=0, state <= IDLE, regardless of current state. This includes reset mid-operation.
- All outputs are decoded from the current state only (Moore); none depend combinationally on inputs. At reset all outputs are 0.
- States and their outputs:
  - IDLE: all outputs 0. start=1 -> LOAD, else stay in IDLE.
  - LOAD: load=1. Always -> CHECK.
  - CHECK: all outputs 0. Samples {q_0,q_1}: 2'b10 -> SUB; 2'b01 -> ADD; 2'b00 or 2'b11 -> SHIFT.
  - ADD: add=1. Always -> SHIFT.
  - SUB: sub=1. Always -> SHIFT.
  - SHIFT: shift=1 and decr=1 together. count <= 1 -> DONE (last iteration; count==0 is treated the same to avoid wrap-around lock-up). Otherwise -> CHECK.
  - DONE: done=1 for exactly one cycle. Always -> IDLE.
- At most one of load/add/sub is high in any cycle. shift and decr are always equal.
- start is ignored in every state except IDLE; it is not queued.
- Per iteration: 2 cycles (CHECK, SHIFT) for pattern 00/11; 3 cycles (CHECK, ADD/SUB, SHIFT) for 01/10.
- Total latency from start sampled to done high: 1 (LOAD) + sum of iteration cycles + 1.
- State encoding is free. Unused encodings must return to IDLE on the next edge.
- An X/Z on q_0/q_1 in CHECK is not protected against; the bench must drive them legally.

Optional Feature:
- CU_BUSY_EN: when defined, adds output port busy (1 bit). busy=1 in LOAD, CHECK, ADD, SUB, SHIFT; busy=0 in IDLE and DONE; busy=0 at reset.
- When undefined, the port and its logic are absent. All other behaviour is identical either way.

Test Plan:
- Reset: rst_n=0 for 2 edges while in SHIFT -> next state IDLE; load=add=sub=shift=decr=done=0.
- Start with N=3, {q_0,q_1}=00 held: sequence LOAD, CHECK, SHIFT, CHECK, SHIFT, CHECK, SHIFT, DONE. Three shift/decr pulses (count 3->2->1 driven by the bench model), then done high exactly one cycle at cycle 8.
- Start with N=1, {q_0,q_1}=10 at CHECK -> sub=1 for one cycle, then shift=decr=1, then done. No add pulse.
- Start with N=2, pattern 01 in the first CHECK and 11 in the second -> add pulse, shift, CHECK, shift, done. add is never coincident with shift.
- start pulsed during ADD and during DONE -> ignored; FSM returns to IDLE and waits for a fresh start.
- count=0 presented in SHIFT -> DONE next cycle, no wrap. With CU_BUSY_EN defined, busy=1 from LOAD through SHIFT and 0 in DONE.

Source files
------------

// File: rtl/booth_control_unit.sv
// Moore sequencer for a radix-2 Booth multiplier datapath: one-hot strobes per state.
// Optional `define CU_BUSY_EN adds a busy output, high from LOAD through SHIFT.
module booth_control_unit #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q_0,
  input  logic             q_1,
  input  logic [CNT_W-1:0] count,
  output logic             load,
  output logic             add,
  output logic             sub,
  output logic             shift,
  output logic             decr,
  output logic             done
`ifdef CU_BUSY_EN
  ,
  output logic             busy
`endif
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StAdd   = 3'd3,
    StSub   = 3'd4,
    StShift = 3'd5,
    StDone  = 3'd6
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = start ? StLoad : StIdle;
      StLoad:  state_d = StCheck;
      StCheck: begin
        case ({q_0, q_1})
          2'b10:   state_d = StSub;
          2'b01:   state_d = StAdd;
          default: state_d = StShift;
        endcase
      end
      StAdd:   state_d = StShift;
      StSub:   state_d = StShift;
      // count==0 also finishes so a bad counter value cannot wrap and lock us in.
      StShift: state_d = (count <= CNT_W'(1)) ? StDone : StCheck;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state, so they always reflect state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      load    <= 1'b0;
      add     <= 1'b0;
      sub     <= 1'b0;
      shift   <= 1'b0;
      decr    <= 1'b0;
      done    <= 1'b0;
`ifdef CU_BUSY_EN
      busy    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      load    <= (state_d == StLoad);
      add     <= (state_d == StAdd);
      sub     <= (state_d == StSub);
      shift   <= (state_d == StShift);
      decr    <= (state_d == StShift);
      done    <= (state_d == StDone);
`ifdef CU_BUSY_EN
      busy    <= (state_d == StLoad) || (state_d == StCheck) || (state_d == StAdd) ||
                 (state_d == StSub) || (state_d == StShift);
`endif
    end
  end

  a_shift_decr: assert property (@(posedge clk) shift == decr);
  a_one_op: assert property (@(posedge clk) $onehot0({load, add, sub, shift}));

endmodule

// File: tb/tb_booth_control_unit.sv
// Randomized self-checking bench for booth_control_unit against a per-iteration cycle model.
module tb_booth_control_unit;

  localparam int unsigned CNT_W = 2;

`ifdef CU_BUSY_EN
  localparam logic BUSY_ON = 1'b1;
`else
  localparam logic BUSY_ON = 1'b0;
`endif

  // Expected output vectors {busy, load, add, sub, shift, decr, done} per phase.
  localparam logic [6:0] E_IDLE  = 7'b0_000000;
  localparam logic [6:0] E_LOAD  = {BUSY_ON, 6'b100000};
  localparam logic [6:0] E_CHECK = {BUSY_ON, 6'b000000};
  localparam logic [6:0] E_ADD   = {BUSY_ON, 6'b010000};
  localparam logic [6:0] E_SUB   = {BUSY_ON, 6'b001000};
  localparam logic [6:0] E_SHIFT = {BUSY_ON, 6'b000110};
  localparam logic [6:0] E_DONE  = 7'b0_000001;

  logic             clk = 1'b0;
  logic             rst_n, start, q_0, q_1;
  logic [CNT_W-1:0] count;
  logic             load, add, sub, shift, decr, done;
  logic             busy_w;

  booth_control_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .q_0   (q_0),
    .q_1   (q_1),
    .count (count),
    .load  (load),
    .add   (add),
    .sub   (sub),
    .shift (shift),
    .decr  (decr),
    .done  (done)
`ifdef CU_BUSY_EN
    ,
    .busy  (busy_w)
`endif
  );

`ifndef CU_BUSY_EN
  assign busy_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {busy_w, load, add, sub, shift, decr, done};
  endfunction

  // Per-cycle expectation: outputs in that cycle and the inputs driven during it.
  string            nm_q[$];
  logic [6:0]       exp_q[$];
  logic [1:0]       qp_q[$];
  logic [CNT_W-1:0] cnt_q[$];
  logic             st_q[$];
  logic [1:0]       pat_buf[4];

  task automatic push(input string nm, input logic [6:0] e, input logic [1:0] qp,
                      input logic [CNT_W-1:0] c, input logic s);
    nm_q.push_back(nm);
    exp_q.push_back(e);
    qp_q.push_back(qp);
    cnt_q.push_back(c);
    st_q.push_back(s);
  endtask

  function automatic logic stv(input bit spam);
    return spam ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // Multiply with N iterations using pat_buf; zero_at forces count=0 in that iteration.
  task automatic run_op(input int n, input int zero_at, input bit spam, input bit rst_in_shift);
    logic [CNT_W-1:0] c;
    logic [1:0]       p;
    nm_q.delete(); exp_q.delete(); qp_q.delete(); cnt_q.delete(); st_q.delete();
    push("idle_start", E_IDLE, 2'($urandom), CNT_W'($urandom), 1'b1);
    push("load", E_LOAD, 2'($urandom), CNT_W'($urandom), stv(spam));
    for (int i = 0; i < n; i++) begin
      c = (i == zero_at) ? '0 : CNT_W'(n - i);
      p = pat_buf[i];
      push("check", E_CHECK, p, CNT_W'($urandom), stv(spam));
      if (p == 2'b01) push("add", E_ADD, 2'($urandom), CNT_W'($urandom), stv(spam));
      if (p == 2'b10) push("sub", E_SUB, 2'($urandom), CNT_W'($urandom), stv(spam));
      push("shift", E_SHIFT, 2'($urandom), c, stv(spam));
      if (c <= 1) break;
    end
    push("done", E_DONE, 2'($urandom), CNT_W'($urandom), stv(spam));
    push("idle_hold", E_IDLE, 2'($urandom), CNT_W'($urandom), 1'b0);

    for (int j = 0; j < exp_q.size(); j++) begin
      check_eq(nm_q[j], outs(), exp_q[j]);
      if (rst_in_shift && nm_q[j] == "shift") begin
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_mid_op", outs(), E_IDLE);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_idle_hold", outs(), E_IDLE);
        return;
      end
      {q_0, q_1} = qp_q[j];
      count      = cnt_q[j];
      start      = st_q[j];
      @(posedge clk);
      #1;
    end
    check_eq("idle_after", outs(), E_IDLE);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    q_0   = 1'b0;
    q_1   = 1'b0;
    count = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset", outs(), E_IDLE);
    rst_n = 1'b1;

    pat_buf = '{2'b00, 2'b00, 2'b00, 2'b00};
    run_op(3, -1, 1'b0, 1'b0);
    pat_buf = '{2'b10, 2'b00, 2'b00, 2'b00};
    run_op(1, -1, 1'b0, 1'b0);
    pat_buf = '{2'b01, 2'b11, 2'b00, 2'b00};
    run_op(2, -1, 1'b0, 1'b0);
    pat_buf = '{2'b01, 2'b10, 2'b00, 2'b00};
    run_op(2, -1, 1'b1, 1'b0);
    pat_buf = '{2'b11, 2'b01, 2'b10, 2'b00};
    run_op(3, 0, 1'b0, 1'b0);
    pat_buf = '{2'b00, 2'b01, 2'b10, 2'b00};
    run_op(3, -1, 1'b0, 1'b1);

    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 4; i++) pat_buf[i] = 2'($urandom);
      run_op(int'($urandom_range(1, 3)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1,
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
